// File: rtl/fp16_norm_round_if.sv
// Handshake and data bundle for the FP16 normalize/round stage.
// The master drives beats in and accepts results; the slave is the stage itself.
interface fp16_norm_round_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [4:0]  in_exp;
    logic [13:0] in_frac;
    logic        in_special;
    logic [15:0] in_special_val;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic        out_overflow;
    logic        out_underflow;
    logic        out_inexact;

    modport master (
        output in_valid, in_sign, in_exp, in_frac,
        output in_special, in_special_val, out_ready,
        input  in_ready, out_valid, out_result,
        input  out_overflow, out_underflow, out_inexact
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_frac,
        input  in_special, in_special_val, out_ready,
        output in_ready, out_valid, out_result,
        output out_overflow, out_underflow, out_inexact
    );
endinterface

// File: rtl/fp16_norm_round.sv
// FP16 adder post-add stage: S1 normalizes the raw sum, S2 rounds
// to nearest-even and packs the result with status flags.
module left_shift (
    input  logic [12:0] din,
    output logic [12:0] dout,
    output logic [3:0]  shift
);
    // Leading-one detect; the highest set bit wins, zero input gives shift 0.
    always_comb begin
        shift = 4'd0;
        for (int i = 0; i <= 12; i++) begin
            if (din[i]) shift = 4'(12 - i);
        end
        dout = din << shift;
    end
endmodule

module fp16_norm_round #(
    parameter int BIAS = 15
) (
    input logic clk,
    input logic rst,
    fp16_norm_round_if.slave bus
);
    logic        s1_valid;
    logic        s1_sign;
    logic [6:0]  s1_exp;
    logic [12:0] s1_frac;
    logic        s1_zero;
    logic        s1_special;
    logic [15:0] s1_sval;

    logic        s2_valid;
    logic [15:0] s2_result;
    logic        s2_ovf;
    logic        s2_unf;
    logic        s2_inx;

    logic        adv;
    logic [12:0] ls_out;
    logic [3:0]  ls_shift;
    logic [6:0]  e_in;

    logic        n_sign;
    logic [6:0]  n_exp;
    logic [12:0] n_frac;
    logic        n_zero;

    logic [9:0]  man;
    logic        lsb;
    logic        g;
    logic        st;
    logic        rnd;
    logic [10:0] msum;
    logic [6:0]  e2;
    logic [15:0] r_result;
    logic        r_ovf;
    logic        r_unf;
    logic        r_inx;

    assign adv          = !s2_valid || bus.out_ready;
    assign bus.in_ready = !s1_valid || adv;
    assign e_in         = {2'b00, bus.in_exp};

    left_shift u_ls (
        .din   (bus.in_frac[12:0]),
        .dout  (ls_out),
        .shift (ls_shift)
    );

    // Normalize: carry shifts right keeping sticky, otherwise leading-one left shift.
    always_comb begin
        n_sign = bus.in_sign;
        n_frac = ls_out;
        n_exp  = e_in - {3'b000, ls_shift};
        n_zero = 1'b0;
        if (bus.in_frac[13]) begin
            n_frac = {bus.in_frac[13:2], bus.in_frac[1] | bus.in_frac[0]};
            n_exp  = e_in + 7'd1;
        end else if (bus.in_frac[12:0] == 13'd0) begin
            n_zero = 1'b1;
            n_sign = 1'b0;
            n_frac = 13'd0;
            n_exp  = 7'd0;
        end
    end

    // S1 register: loads whenever the stage can accept a beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (bus.in_ready) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_sign    <= n_sign;
                s1_exp     <= n_exp;
                s1_frac    <= n_frac;
                s1_zero    <= n_zero;
                s1_special <= bus.in_special;
                s1_sval    <= bus.in_special_val;
            end
        end
    end

    // Round to nearest-even, then saturate, flush or pack.
    always_comb begin
        man      = s1_frac[11:2];
        lsb      = s1_frac[2];
        g        = s1_frac[1];
        st       = s1_frac[0];
        rnd      = g && (st || lsb);
        msum     = {1'b0, man} + {10'd0, rnd};
        e2       = s1_exp + {6'd0, msum[10]};
        r_result = {s1_sign, e2[4:0], msum[9:0]};
        r_ovf    = 1'b0;
        r_unf    = 1'b0;
        r_inx    = g | st;
        if (s1_special) begin
            r_result = s1_sval;
            r_inx    = 1'b0;
        end else if (s1_zero) begin
            r_result = 16'h0000;
            r_inx    = 1'b0;
        end else if ($signed(e2) >= 7'sd31) begin
            r_result = {s1_sign, 5'h1F, 10'h000};
            r_ovf    = 1'b1;
            r_inx    = 1'b1;
        end else if ($signed(e2) <= 7'sd0) begin
            r_result = {s1_sign, 15'h0000};
            r_unf    = 1'b1;
            r_inx    = |s1_frac;
        end
    end

    // S2 register: holds while full and the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            s2_result <= 16'h0000;
            s2_ovf    <= 1'b0;
            s2_unf    <= 1'b0;
            s2_inx    <= 1'b0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_result <= r_result;
                s2_ovf    <= r_ovf;
                s2_unf    <= r_unf;
                s2_inx    <= r_inx;
            end
        end
    end

    assign bus.out_valid     = s2_valid;
    assign bus.out_result    = s2_result;
    assign bus.out_overflow  = s2_ovf;
    assign bus.out_underflow = s2_unf;
    assign bus.out_inexact   = s2_inx;
endmodule

// File: tb/tb_fp16_norm_round.sv
// Directed bench for fp16_norm_round: vector table, burst with
// back-pressure, back-to-back throughput and mid-flight reset.
module tb_fp16_norm_round;
    typedef struct {
        logic        sign;
        logic [4:0]  exp;
        logic [13:0] frac;
        logic        special;
        logic [15:0] sval;
        logic [15:0] res;
        logic        ovf;
        logic        unf;
        logic        inx;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;
    vec_t vt[16];

    always #5 clk = ~clk;

    fp16_norm_round_if bus ();

    fp16_norm_round #(.BIAS(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.in_sign        = v.sign;
        bus.in_exp         = v.exp;
        bus.in_frac        = v.frac;
        bus.in_special     = v.special;
        bus.in_special_val = v.sval;
    endtask

    function automatic logic [31:0] outs();
        return {13'd0, bus.out_result, bus.out_overflow, bus.out_underflow, bus.out_inexact};
    endfunction

    function automatic logic [31:0] want(input vec_t v);
        return {13'd0, v.res, v.ovf, v.unf, v.inx};
    endfunction

    initial begin
        int   sent;
        int   rcv;
        int   infl;
        int   bidx[4];
        logic acc;
        logic drn;
        logic [15:0] q[$];

        vt[0]  = '{1'b0, 5'd15, 14'h2000, 1'b0, 16'h0, 16'h4000, 1'b0, 1'b0, 1'b0};
        vt[1]  = '{1'b0, 5'd15, 14'h0200, 1'b0, 16'h0, 16'h3000, 1'b0, 1'b0, 1'b0};
        vt[2]  = '{1'b0, 5'd2,  14'h0200, 1'b0, 16'h0, 16'h0000, 1'b0, 1'b1, 1'b1};
        vt[3]  = '{1'b0, 5'd15, 14'h1002, 1'b0, 16'h0, 16'h3C00, 1'b0, 1'b0, 1'b1};
        vt[4]  = '{1'b0, 5'd15, 14'h1006, 1'b0, 16'h0, 16'h3C02, 1'b0, 1'b0, 1'b1};
        vt[5]  = '{1'b0, 5'd15, 14'h1FFF, 1'b0, 16'h0, 16'h4000, 1'b0, 1'b0, 1'b1};
        vt[6]  = '{1'b1, 5'd30, 14'h2000, 1'b0, 16'h0, 16'hFC00, 1'b1, 1'b0, 1'b1};
        vt[7]  = '{1'b1, 5'd10, 14'h0000, 1'b0, 16'h0, 16'h0000, 1'b0, 1'b0, 1'b0};
        vt[8]  = '{1'b0, 5'd30, 14'h1FFF, 1'b1, 16'h7E00, 16'h7E00, 1'b0, 1'b0, 1'b0};
        vt[9]  = '{1'b0, 5'd15, 14'h2003, 1'b0, 16'h0, 16'h4000, 1'b0, 1'b0, 1'b1};
        vt[10] = '{1'b0, 5'd15, 14'h3FFE, 1'b0, 16'h0, 16'h4400, 1'b0, 1'b0, 1'b1};
        vt[11] = '{1'b1, 5'd0,  14'h1000, 1'b0, 16'h0, 16'h8000, 1'b0, 1'b1, 1'b1};
        vt[12] = '{1'b0, 5'd30, 14'h1FFF, 1'b0, 16'h0, 16'h7C00, 1'b1, 1'b0, 1'b1};
        vt[13] = '{1'b0, 5'd15, 14'h0001, 1'b0, 16'h0, 16'h0C00, 1'b0, 1'b0, 1'b0};
        vt[14] = '{1'b0, 5'd30, 14'h1000, 1'b0, 16'h0, 16'h7800, 1'b0, 1'b0, 1'b0};
        vt[15] = '{1'b1, 5'd15, 14'h1000, 1'b0, 16'h0, 16'hBC00, 1'b0, 1'b0, 1'b0};

        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        drive(vt[0]);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_valid", bus.out_valid, 0);
        chk("reset_outs", outs(), 0);
        chk("reset_ready", bus.in_ready, 1);

        // single beats, 2-cycle latency
        for (int i = 0; i < 16; i++) begin
            drive(vt[i]);
            bus.in_valid = 1'b1;
            @(posedge clk);
            #1 bus.in_valid = 1'b0;
            chk($sformatf("lat_v%0d", i), bus.out_valid, 0);
            @(posedge clk);
            #1;
            chk($sformatf("valid_v%0d", i), bus.out_valid, 1);
            chk($sformatf("vec%0d", i), outs(), want(vt[i]));
        end
        @(posedge clk);
        #1 chk("drained", bus.out_valid, 0);

        // burst with out_ready toggling 1,0,0,1
        bidx = '{0, 1, 3, 4};
        sent = 0;
        rcv = 0;
        infl = 0;
        for (int c = 0; c < 40 && rcv < 4; c++) begin
            bus.out_ready = (c % 4 == 0) || (c % 4 == 3);
            bus.in_valid = (sent < 4);
            if (sent < 4) drive(vt[bidx[sent]]);
            #1;
            chk("burst_in_ready", bus.in_ready, !(infl == 2 && !bus.out_ready));
            acc = bus.in_valid && bus.in_ready;
            drn = bus.out_valid && bus.out_ready;
            if (drn) begin
                chk("burst_nonempty", q.size() > 0, 1);
                if (q.size() > 0) begin
                    chk("burst_order", bus.out_result, q.pop_front());
                    rcv++;
                end
            end
            if (acc) begin
                q.push_back(vt[bidx[sent]].res);
                sent++;
            end
            infl = infl + int'(acc) - int'(drn);
            @(posedge clk);
            #1;
        end
        chk("burst_count", rcv, 4);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 chk("burst_empty", bus.out_valid, 0);

        // back-to-back, one result per cycle
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = (k < 3);
            if (k < 3) drive(vt[k + 9]);
            @(posedge clk);
            #1;
            if (k >= 1 && k <= 3) begin
                chk($sformatf("thru_valid%0d", k), bus.out_valid, 1);
                chk($sformatf("thru%0d", k), outs(), want(vt[k + 8]));
            end
        end
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;

        // fill both stages under stall, then reset
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        drive(vt[0]);
        @(posedge clk);
        #1 drive(vt[1]);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        chk("full_ready", bus.in_ready, 0);
        chk("full_out", outs(), want(vt[0]));
        @(posedge clk);
        #1 chk("stall_hold", outs(), want(vt[0]));
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_mid_valid", bus.out_valid, 0);
        chk("rst_mid_outs", outs(), 0);
        chk("rst_mid_ready", bus.in_ready, 1);
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        drive(vt[6]);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        chk("post_rst_lat", bus.out_valid, 0);
        @(posedge clk);
        #1;
        chk("post_rst_valid", bus.out_valid, 1);
        chk("post_rst_res", outs(), want(vt[6]));
        @(posedge clk);
        #1 chk("post_rst_drain", bus.out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fp16_norm_round.md
Name: fp16_norm_round

Overview:
- Post-addition normalize and round stage of the FP16 adder inside the systolic-array MAC unit; sits directly downstream of the alignment/add stage.
- Takes a raw 14-bit sum fraction, biased exponent and sign, and produces a packed IEEE FP16 result with status flags.
- Two-stage pipeline with valid/ready handshake:
  - S1 normalizes, either a 1-bit right shift on carry or a leading-one left shift using the existing 13-bit left_shift block.
  - S2 rounds to nearest-even and packs the result.

Parameters:
- BIAS, 15, FP16 exponent bias; used only for documentation/assertions, since the format is fixed at FP16.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage can accept a beat.
- in_sign  in  1  sign of the sum.
- in_exp  in  5  biased exponent of the larger operand.
- in_frac  in  14  raw sum; bit layout:
  - [13] carry-out
  - [12] hidden bit
  - [11:2] mantissa
  - [1] guard
  - [0] sticky
- in_special  in  1  operand was inf/NaN; bypass arithmetic.
- in_special_val  in  16  result to emit when in_special=1.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  16  packed FP16 {sign, exp[4:0], man[9:0]}.
- out_overflow  out  1  result saturated to ±inf.
- out_underflow  out  1  result flushed to ±0.
- out_inexact  out  1  guard or sticky was nonzero.

Behaviour:
- Reset (synchronous, active-high) clears both stage valid bits.
  - out_valid=0; out_result=16'h0000; all flags 0.
  - Reset mid-operation discards in-flight beats; in_ready=1 the cycle after reset deasserts.
- Handshake:
  - A beat transfers on in_valid&&in_ready at the input and on out_valid&&out_ready at the output.
  - in_ready = !s1_valid || !s2_valid || out_ready.
  - S2 advances when !s2_valid || out_ready; S1 advances into S2 under the same condition.
  - Latency is 2 cycles; throughput is 1 beat/cycle with out_ready held high.
  - While out_ready=0 and both stages are full, outputs and stage registers hold stable.
  - Simultaneous input accept and output drain in the same cycle loses no beat.
- S1 normalize; exponent arithmetic is 7-bit signed, e = {2'b00, in_exp}:
  - in_frac[13]=1: frac = in_frac>>1, with the new bit0 = in_frac[1] | in_frac[0] (sticky preserved); e = e+1.
  - Else if in_frac[12:0]==0: zero flag set, sign forced to 0 (exact cancellation gives +0).
  - Else: the left_shift instance normalizes in_frac[12:0] to a leading 1 and returns shift s (0..12); e = e-s. Zeros enter from the right; bit0 is treated as data.
  - in_special bypasses all of the above and S2 arithmetic; in_special_val is forwarded unchanged with all flags 0.
- S2 round, then pack:
  - lsb = frac[2], g = frac[1], st = frac[0].
  - Round up when g && (st || lsb); inexact = g | st.
  - If mantissa+1 overflows 10 bits: mantissa = 0, e = e+1.
  - If e >= 31: result = {sign, 5'h1F, 10'h0}, overflow=1, inexact=1.
  - If e <= 0: result = {sign, 15'h0}, underflow=1, inexact=1 if the fraction was nonzero. No denormals are produced.
  - Zero flag set: result = 16'h0000, all flags 0.
  - Otherwise: result = {sign, e[4:0], mantissa}.
- Outputs are registered from S2 only; there is no combinational path from in_* to out_*.

Test Plan:
- in_frac=14'h2000, in_exp=15, sign=0 (1.0+1.0) -> out_result=16'h4000 after 2 cycles; flags 0.
- in_frac=14'h0200, in_exp=15 (cancellation, shift 3) -> 16'h3000; then in_frac=14'h0200, in_exp=2 -> 16'h0000 with underflow=1.
- Rounding cases:
  - in_frac=14'h1002, exp=15 (tie, lsb 0) -> 16'h3C00, inexact=1.
  - in_frac=14'h1006 (tie, lsb 1) -> 16'h3C02.
  - in_frac=14'h1FFF -> 16'h4000, inexact=1.
- in_frac=14'h2000, in_exp=30, sign=1 -> 16'hFC00, overflow=1. Separately, in_frac=0, sign=1 -> 16'h0000.
- in_special=1, in_special_val=16'h7E00 -> 16'h7E00, flags 0. Issue a 4-beat burst with out_ready toggling 1,0,0,1,... -> all 4 results emerge in order, none dropped or duplicated; in_ready=0 only when both stages are full and out_ready=0.
- Assert rst for 1 cycle while 2 beats are in flight -> out_valid=0 the next cycle, out_result=0; a new beat issued afterwards emerges exactly 2 cycles later.
